// File: rtl/uart_tx_fifo_if.sv
// Store-path bus from the memory controller into the UART TX block.
// The master drives a byte and a one-cycle write strobe.
interface uart_tx_fifo_if;
  logic [7:0] uart;
  logic       uart_we;

  modport master (
    output uart,
    output uart_we
  );

  modport slave (
    input uart,
    input uart_we
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter: buffers store-path bytes in a FIFO and
// serializes them as 8N1 frames at a fixed baud divider.
module uart_tx_fifo #(
  parameter  int CLKS_PER_BIT = 868,
  parameter  int FIFO_DEPTH   = 16,
  localparam int AW           = $clog2(FIFO_DEPTH),
  localparam int CW           = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_fifo_if.slave wr,
  output logic          txd,
  output logic          busy,
  output logic          fifo_full,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0]   LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [15:0]   baud;
  logic [2:0]    bidx;
  logic [7:0]    shift;
  logic [7:0]    head;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bit_end;

  assign fifo_full = fifo_count == DEPTH;
  assign empty     = fifo_count == '0;
  assign push      = wr.uart_we && !fifo_full;
  assign bit_end   = baud == LAST;
  assign busy      = state != IDLE;
  assign head      = mem[rptr];

  // Pop on idle or on the last stop cycle, so frames run back-to-back.
  assign pop = !empty &&
               (state == IDLE ||
                (state == STOP && bit_end));

  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem[wptr] <= wr.uart;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= wr.uart_we && fifo_full;
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      txd   <= 1'b1;
      baud  <= '0;
      bidx  <= '0;
      shift <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          txd  <= 1'b1;
          baud <= '0;
          if (pop) begin
            shift <= head;
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud  <= '0;
            bidx  <= '0;
            state <= DATA;
            txd   <= shift[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bidx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bidx  <= bidx + 3'd1;
              shift <= {1'b0, shift[7:1]};
              txd   <= shift[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              shift <= head;
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
